// File: rtl/pot_smoother.sv
`default_nettype none
// ============================================================================
//  Module   : pot_smoother
//  Purpose  : Per-channel first-order IIR low-pass for the six slide-pot
//             registers (LP, B1, B2, B3, HP, VOLUME). One shared adder is
//             time-multiplexed across the channels. Each tick runs one sweep,
//             and a sweep updates one channel per clock.
//  Ports    : clk            system clock
//             rst            synchronous, active-high reset
//             tick           sweep request (1-cycle pulse)
//             POT_LP..POT_HP raw band pots, 12-bit unsigned
//             VOLUME         raw volume pot, 12-bit unsigned
//             SM_LP..SM_HP   smoothed band gains, 12-bit
//             SM_VOL         smoothed volume, 12-bit
//             sm_vld         1-cycle pulse when a sweep has finished
//             busy           high while a sweep is in progress
//  Params   : SHIFT    IIR coefficient 2^-SHIFT (1..6)
//             DEADBAND output hysteresis in LSBs (POT_DEADBAND_EN only)
//  Config   : define POT_DEADBAND_EN to enable output hysteresis
//  Revision : 1.0  initial release
// ============================================================================
module pot_smoother #(
   parameter int SHIFT    = 3,
   parameter int DEADBAND = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [11:0] POT_LP,
   input  logic [11:0] POT_B1,
   input  logic [11:0] POT_B2,
   input  logic [11:0] POT_B3,
   input  logic [11:0] POT_HP,
   input  logic [11:0] VOLUME,
   output logic [11:0] SM_LP,
   output logic [11:0] SM_B1,
   output logic [11:0] SM_B2,
   output logic [11:0] SM_B3,
   output logic [11:0] SM_HP,
   output logic [11:0] SM_VOL,
   output logic        sm_vld,
   output logic        busy
);

   localparam int AW = 12 + SHIFT;

`ifdef POT_DEADBAND_EN
   localparam logic DB_EN = 1'b1;
`else
   localparam logic DB_EN = 1'b0;
`endif

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      idx;
   logic [2:0]      idx_nxt;
   logic            wr;
   logic            last;
   logic            primed;

   logic [AW-1:0]   acc [0:5];
   logic [11:0]     sm  [0:5];

   logic [11:0]     x;
   logic [AW-1:0]   acc_cur;
   logic [11:0]     sm_cur;
   logic [AW-1:0]   acc_nxt;
   logic [11:0]     cand;
   logic [11:0]     diff;
   logic            sm_upd;

   // ------------------------------------------------------------------------
   // Sequencer: IDLE waits for tick; SWEEP writes channel idx on every edge.
   // Ticks that arrive during SWEEP are dropped, not queued.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wr        = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (tick) begin
               state_nxt = SWEEP;
               idx_nxt   = 3'd0;
            end
         end
         SWEEP: begin
            wr = 1'b1;
            if (idx == 3'd5) begin
               last      = 1'b1;
               state_nxt = IDLE;
               idx_nxt   = 3'd0;
            end else begin
               idx_nxt = idx + 3'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Channel multiplexer feeding the shared datapath.
   // ------------------------------------------------------------------------
   always_comb begin
      x       = '0;
      acc_cur = '0;
      sm_cur  = '0;
      case (idx)
         3'd0: begin x = POT_LP; acc_cur = acc[0]; sm_cur = sm[0]; end
         3'd1: begin x = POT_B1; acc_cur = acc[1]; sm_cur = sm[1]; end
         3'd2: begin x = POT_B2; acc_cur = acc[2]; sm_cur = sm[2]; end
         3'd3: begin x = POT_B3; acc_cur = acc[3]; sm_cur = sm[3]; end
         3'd4: begin x = POT_HP; acc_cur = acc[4]; sm_cur = sm[4]; end
         3'd5: begin x = VOLUME; acc_cur = acc[5]; sm_cur = sm[5]; end
         default: begin x = '0; acc_cur = '0; sm_cur = '0; end
      endcase
   end

   // Shared adder. acc - (acc >> SHIFT) never underflows, and the sum is
   // bounded by 4095*2^SHIFT + 2^SHIFT - 1, which fits in AW bits.
   always_comb begin
      acc_nxt = acc_cur - (acc_cur >> SHIFT) + {{SHIFT{1'b0}}, x};
      cand    = acc_nxt[AW-1:SHIFT];
      diff    = (cand >= sm_cur) ? (cand - sm_cur) : (sm_cur - cand);
      // Rail values always pass so that a steady 0x000/0xFFF input is reached
      // exactly even from inside the hysteresis window.
      sm_upd  = !DB_EN || (diff > 12'(DEADBAND)) ||
                (cand == 12'h000) || (cand == 12'hFFF);
   end

   // ------------------------------------------------------------------------
   // State, accumulators and outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= 3'd0;
         sm_vld <= 1'b0;
         primed <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            acc[i] <= '0;
            sm[i]  <= '0;
         end
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         sm_vld <= last;
         if (last) begin
            primed <= 1'b1;
         end
         if (wr) begin
            for (int i = 0; i < 6; i++) begin
               if (idx == 3'(i)) begin
                  if (!primed) begin
                     // First sweep after reset: jump straight to the input
                     // so the outputs do not ramp up from zero.
                     acc[i] <= {x, {SHIFT{1'b0}}};
                     sm[i]  <= x;
                  end else begin
                     acc[i] <= acc_nxt;
                     if (sm_upd) begin
                        sm[i] <= cand;
                     end
                  end
               end
            end
         end
      end
   end

   assign busy   = (state == SWEEP);
   assign SM_LP  = sm[0];
   assign SM_B1  = sm[1];
   assign SM_B2  = sm[2];
   assign SM_B3  = sm[3];
   assign SM_HP  = sm[4];
   assign SM_VOL = sm[5];

endmodule
`default_nettype wire
